gamma_lut_mapper: RTL

GAMMA_LUT_MAPPER -- requirements
Module: gamma_lut_mapper

---
 rtl/gamma_lut_pkg.sv | 22 ++
 rtl/gamma_lut_mapper_if.sv | 26 ++
 rtl/gamma_lut_channel.sv | 47 ++++
 rtl/gamma_lut_mapper.sv | 135 +++++++++++++
 4 files changed

// File: rtl/gamma_lut_pkg.sv
// Shared FSM state type and default sizing for the gamma LUT mapper.
`ifndef RAM_WIDTH
`define RAM_WIDTH 16
`endif

package gamma_lut_pkg;

  localparam int DEF_CHANNELS = 3;
  localparam int DEF_DW       = 8;
  localparam int DEF_AW       = `RAM_WIDTH;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    PENDING
  } lut_state_e;

  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/gamma_lut_mapper_if.sv
// LUT configuration bus: write handshake plus bank-commit request.
interface gamma_lut_mapper_if
  import gamma_lut_pkg::*;
#(
  parameter int CW = chan_width(DEF_CHANNELS),
  parameter int DW = DEF_DW
);

  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_chan;
  logic [DW-1:0] cfg_index;
  logic [DW-1:0] cfg_data;
  logic          cfg_commit;

  modport master (
    output cfg_valid, cfg_chan, cfg_index, cfg_data, cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_index, cfg_data, cfg_commit,
    output cfg_ready
  );

endinterface

// File: rtl/gamma_lut_channel.sv
// One colour channel: double-banked LUT, shared write port, registered
// lookup with bypass/identity override, then an output register.
module gamma_lut_channel
  import gamma_lut_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          bypass,
  input  logic          identity,
  input  logic          rd_bank,
  input  logic [DW-1:0] pix,
  input  logic [1:0]    wr_en,
  input  logic [DW-1:0] wr_index,
  input  logic [DW-1:0] wr_value,
  output logic [DW-1:0] mapped
);

  localparam int DEPTH = 2 ** DW;

  logic [DW-1:0] bank0 [DEPTH];
  logic [DW-1:0] bank1 [DEPTH];
  logic [DW-1:0] lookup;
  logic [DW-1:0] stage;

  // wr_en bit b selects bank b; INIT drives both bits together
  always_ff @(posedge clock) begin
    if (wr_en[0]) bank0[wr_index] <= wr_value;
    if (wr_en[1]) bank1[wr_index] <= wr_value;
  end

  always_comb begin
    lookup = rd_bank ? bank1[pix] : bank0[pix];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage  <= '0;
      mapped <= '0;
    end else begin
      stage  <= (bypass || identity) ? pix : lookup;
      mapped <= stage;
    end
  end

endmodule

// File: rtl/gamma_lut_mapper.sv
// Per-channel gamma LUT mapping with shadow-bank configuration and
// frame-synchronous bank swap; pixel sideband delayed to match.
module gamma_lut_mapper
  import gamma_lut_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int CW       = chan_width(CHANNELS)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   bypass,
  input  logic                   in_wren,
  input  logic [AW-1:0]          in_wraddr,
  input  logic [CHANNELS*DW-1:0] in_data,
  input  logic                   in_starttrigger,
  gamma_lut_mapper_if.slave      cfg,
  output logic                   swap_pending,
  output logic                   active_bank,
  output logic                   wren,
  output logic [AW-1:0]          wraddr,
  output logic [CHANNELS*DW-1:0] wrdata,
  output logic                   starttrigger
);

  lut_state_e    state;
  lut_state_e    state_next;
  logic [DW-1:0] init_idx;
  logic          init_busy;
  logic          swap;
  logic          cfg_accept;
  logic [DW-1:0] wr_index;
  logic [DW-1:0] wr_value;

  logic          wren_s1;
  logic [AW-1:0] wraddr_s1;
  logic          start_s1;
  logic [DW-1:0] mapped [CHANNELS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INIT;
      init_idx    <= '0;
      active_bank <= 1'b0;
    end else begin
      state <= state_next;
      if (state == INIT) init_idx <= init_idx + 1'b1;
      if (swap) active_bank <= ~active_bank;
    end
  end

  // A commit seen in IDLE only arms the swap; the trigger must come later
  always_comb begin
    state_next    = state;
    cfg.cfg_ready = 1'b0;
    swap_pending  = 1'b0;
    init_busy     = 1'b0;
    swap          = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        if (init_idx == '1) state_next = IDLE;
      end
      IDLE: begin
        cfg.cfg_ready = 1'b1;
        if (cfg.cfg_commit) state_next = PENDING;
      end
      PENDING: begin
        swap_pending = 1'b1;
        if (in_starttrigger) begin
          swap       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    cfg_accept = cfg.cfg_valid && cfg.cfg_ready;
    wr_index   = init_busy ? init_idx : cfg.cfg_index;
    wr_value   = init_busy ? init_idx : cfg.cfg_data;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [1:0] bank_en;

    // Out-of-range cfg_chan matches no channel, so the write is dropped
    assign bank_en = init_busy ? 2'b11 :
                     (cfg_accept && (cfg.cfg_chan == CW'(c))) ?
                       (active_bank ? 2'b01 : 2'b10) : 2'b00;

    gamma_lut_channel #(
      .DW (DW)
    ) u_channel (
      .clock    (clock),
      .reset_n  (reset_n),
      .bypass   (bypass),
      .identity (init_busy),
      .rd_bank  (active_bank),
      .pix      (in_data[(CHANNELS-1-c)*DW +: DW]),
      .wr_en    (bank_en),
      .wr_index (wr_index),
      .wr_value (wr_value),
      .mapped   (mapped[c])
    );
  end

  always_comb begin
    wrdata = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      wrdata[(CHANNELS-1-c)*DW +: DW] = mapped[c];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wren_s1      <= 1'b0;
      wraddr_s1    <= '0;
      start_s1     <= 1'b0;
      wren         <= 1'b0;
      wraddr       <= '0;
      starttrigger <= 1'b0;
    end else begin
      wren_s1      <= in_wren;
      wraddr_s1    <= in_wraddr;
      start_s1     <= in_starttrigger;
      wren         <= wren_s1;
      wraddr       <= wraddr_s1;
      starttrigger <= start_s1;
    end
  end

endmodule
